// File: rtl/wb_data_upsize_pkg.sv
// Shared types and lane helpers for the 8-bit to 32-bit Wishbone upsizer.
// Lane mapping is big-endian: byte offset 0 lives in bits 31:24.
package wb_data_upsize_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic logic [3:0] lane_sel(input logic [1:0] off);
        return 4'b1000 >> off;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_data_upsize_if.sv
// Bus bundle for wb_data_upsize: narrow master side (wbm_*) and wide slave side (wbs_*).
// The bridge uses the slave modport; the surrounding system uses the master modport.
interface wb_data_upsize_if #(
    parameter int aw = 32
);
    // A request is valid while wbm_cyc_i & wbm_stb_i; the bridge answers each one with
    // exactly one single-cycle pulse on wbm_ack_o, wbm_err_o or wbm_rty_o, and the
    // master keeps the request stable until it sees that pulse.
    logic [aw-1:0] wbm_adr_i;
    logic [7:0]    wbm_dat_i;
    logic          wbm_we_i;
    logic          wbm_cyc_i;
    logic          wbm_stb_i;
    logic [2:0]    wbm_cti_i;
    logic [1:0]    wbm_bte_i;
    logic [7:0]    wbm_dat_o;
    logic          wbm_ack_o;
    logic          wbm_err_o;
    logic          wbm_rty_o;

    logic [aw-1:0] wbs_adr_o;
    logic [31:0]   wbs_dat_o;
    logic [3:0]    wbs_sel_o;
    logic          wbs_we_o;
    logic          wbs_cyc_o;
    logic          wbs_stb_o;
    logic [2:0]    wbs_cti_o;
    logic [1:0]    wbs_bte_o;
    logic [31:0]   wbs_dat_i;
    logic          wbs_ack_i;
    logic          wbs_err_i;
    logic          wbs_rty_i;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
        output wbs_cti_o, wbs_bte_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
        input  wbs_cti_o, wbs_bte_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

endinterface

// File: rtl/wb_data_upsize_rdbuf.sv
// One-word read buffer: holds the last fetched 32-bit word with its word-address tag.
// Invalidate wins over fill when both are requested on the same edge.
module wb_data_upsize_rdbuf #(
    parameter int tw = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fill,
    input  logic          invalidate,
    input  logic [31:0]   fill_word,
    input  logic [tw-1:0] fill_tag,
    input  logic [tw-1:0] lookup_tag,
    output logic          hit,
    output logic [31:0]   data
);
    logic          valid;
    logic [tw-1:0] tag;
    logic [31:0]   word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (invalidate) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            word  <= fill_word;
        end
    end

    assign hit  = valid && (tag == lookup_tag);
    assign data = word;

endmodule

// File: rtl/wb_data_upsize.sv
// 8-bit Wishbone master to 32-bit Wishbone slave bridge, one registered slave access per byte.
// Define WB_DATA_UPSIZE_RDBUF_EN to add a one-word read buffer serving same-word reads.
module wb_data_upsize
    import wb_data_upsize_pkg::*;
#(
    parameter int aw = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    wb_data_upsize_if.slave bus,
    output logic [1:0]      dbg_state
);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]  state;
    logic [1:0]  off;
    logic [1:0]  off_q;
    logic        req;
    logic        buf_hit;
    logic [31:0] buf_word;
    logic [3:0]  read_sel;
    logic        unused_cfg;

    assign off           = bus.wbm_adr_i[1:0];
    assign req           = bus.wbm_cyc_i & bus.wbm_stb_i;
    assign bus.wbs_cti_o = 3'b000;
    assign bus.wbs_bte_o = 2'b00;
    assign dbg_state     = state;
    assign unused_cfg    = ^{bus.wbm_cti_i, bus.wbm_bte_i};

`ifdef WB_DATA_UPSIZE_RDBUF_EN
    logic buf_fill;
    logic buf_inval;
    logic buf_tag_hit;

    // Only a read completed by the slave with the master still in its cycle may fill.
    assign buf_fill  = (state == ST_ACCESS) && bus.wbm_cyc_i && bus.wbs_ack_i &&
                       !bus.wbs_err_i && !bus.wbs_rty_i && !bus.wbs_we_o;
    assign buf_inval = !bus.wbm_cyc_i ||
                       ((state == ST_IDLE) && req && bus.wbm_we_i) ||
                       ((state == ST_ACCESS) && (bus.wbs_err_i || bus.wbs_rty_i));

    wb_data_upsize_rdbuf #(.tw(aw - 2)) u_rdbuf (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n_i),
        .fill       (buf_fill),
        .invalidate (buf_inval),
        .fill_word  (bus.wbs_dat_i),
        .fill_tag   (bus.wbs_adr_o[aw-1:2]),
        .lookup_tag (bus.wbm_adr_i[aw-1:2]),
        .hit        (buf_tag_hit),
        .data       (buf_word)
    );

    assign buf_hit  = buf_tag_hit && !bus.wbm_we_i;
    assign read_sel = 4'b1111;
`else
    assign buf_hit  = 1'b0;
    assign buf_word = 32'h0;
    assign read_sel = lane_sel(off);
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= ST_IDLE;
            off_q         <= 2'b00;
            bus.wbm_dat_o <= 8'h00;
            bus.wbm_ack_o <= 1'b0;
            bus.wbm_err_o <= 1'b0;
            bus.wbm_rty_o <= 1'b0;
            bus.wbs_adr_o <= '0;
            bus.wbs_dat_o <= 32'h0;
            bus.wbs_sel_o <= 4'h0;
            bus.wbs_we_o  <= 1'b0;
            bus.wbs_cyc_o <= 1'b0;
            bus.wbs_stb_o <= 1'b0;
        end else begin
            bus.wbm_ack_o <= 1'b0;
            bus.wbm_err_o <= 1'b0;
            bus.wbm_rty_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req && buf_hit) begin
                        bus.wbm_dat_o <= lane_byte(buf_word, off);
                        bus.wbm_ack_o <= 1'b1;
                        state         <= ST_RESP;
                    end else if (req) begin
                        off_q         <= off;
                        bus.wbs_adr_o <= {bus.wbm_adr_i[aw-1:2], 2'b00};
                        bus.wbs_we_o  <= bus.wbm_we_i;
                        bus.wbs_dat_o <= {4{bus.wbm_dat_i}};
                        bus.wbs_sel_o <= bus.wbm_we_i ? lane_sel(off) : read_sel;
                        bus.wbs_cyc_o <= 1'b1;
                        bus.wbs_stb_o <= 1'b1;
                        state         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Master abort outranks any slave response arriving in the same cycle.
                    if (!bus.wbm_cyc_i) begin
                        bus.wbs_cyc_o <= 1'b0;
                        bus.wbs_stb_o <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (bus.wbs_err_i || bus.wbs_rty_i || bus.wbs_ack_i) begin
                        if (bus.wbs_err_i) begin
                            bus.wbm_err_o <= 1'b1;
                        end else if (bus.wbs_rty_i) begin
                            bus.wbm_rty_o <= 1'b1;
                        end else begin
                            bus.wbm_ack_o <= 1'b1;
                            bus.wbm_dat_o <= lane_byte(bus.wbs_dat_i, off_q);
                        end
                        bus.wbs_cyc_o <= 1'b0;
                        bus.wbs_stb_o <= 1'b0;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_data_upsize.md
# wb_data_upsize

Bridges an 8-bit Wishbone master onto a 32-bit Wishbone slave, the narrow-master/wide-slave counterpart of the downsizing data-width adapter in wb_intercon. Each byte access becomes one registered 32-bit slave access with a one-hot byte select and big-endian lane mapping: address offset 0 maps to bits 31:24. An optional one-word read buffer serves consecutive byte reads from the same 32-bit word without further slave accesses. The block sits between a narrow CPU or debug master and the 32-bit interconnect ports.

## Interface
- aw, 32, address width (≥3)
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset; asynchronous, active-low
- wbm_adr_i  in  aw  byte address
- wbm_dat_i  in  8  write data
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  1  master controls
- wbm_cti_i  in  3, wbm_bte_i  in  2  accepted, ignored
- wbm_dat_o  out  8  read data
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  1  responses
- wbs_adr_o  out  aw  word address, bits [1:0] always 0
- wbs_dat_o  out  32  write data
- wbs_sel_o  out  4  byte selects
- wbs_we_o, wbs_cyc_o, wbs_stb_o  out  1  slave controls
- wbs_cti_o  out  3 (always 3'b000), wbs_bte_o  out  2 (always 2'b00)
- wbs_dat_i  in  32, wbs_ack_i, wbs_err_i, wbs_rty_i  in  1

## Operation
- Lane mapping: off = wbm_adr_i[1:0]; sel = 4'b1000 >> off; byte = bits [31-8·off -: 8].
- FSM states: IDLE, ACCESS, RESP.
- IDLE, with cyc&stb and a buffer hit: load wbm_dat_o from the buffer and pulse wbm_ack_o. Go to RESP; there is no slave access.
- IDLE, with cyc&stb and no hit:
  - Register wbs_adr_o = {adr[aw-1:2], 2'b00} and wbs_we_o = wbm_we_i.
  - Register wbs_dat_o = {4{wbm_dat_i}}.
  - Register wbs_sel_o: the lane for writes; 4'b1111 for reads when the buffer is compiled in, otherwise the lane.
  - Assert wbs_cyc_o and wbs_stb_o, then go to ACCESS.
- ACCESS: hold every slave output until the slave responds.
  - wbs_ack_i: register wbm_dat_o = the selected byte and pulse wbm_ack_o. On a read, also fill the buffer (word, tag adr[aw-1:2], valid).
  - wbs_err_i or wbs_rty_i: pulse wbm_err_o or wbm_rty_o and clear the buffer valid flag.
  - Response priority: err > rty > ack.
  - In all three cases, drop wbs_cyc_o and wbs_stb_o and go to RESP.
- RESP: the response pulse is high for exactly this one cycle, then the FSM returns to IDLE.
- Abort: wbm_cyc_i low in ACCESS drops the slave outputs on the next edge and returns to IDLE. There is no master response and no buffer update.
- Any write clears the buffer valid flag. wbm_cyc_i low in any state also clears it.
- wbm_dat_o holds its last value between responses.

## Timing
- Reset: all outputs 0, FSM IDLE, buffer invalid. Reset acts asynchronously mid-access; the slave strobes drop immediately.
- Miss: a request sampled at edge 0 gives wbs_stb_o high after edge 0. With the slave acking in the same cycle, wbm_ack_o is high after edge 1, so minimum latency is 2 cycles.
- Hit: wbm_ack_o is high after edge 0, so latency is 1 cycle.
- After each response the master may present its next request in the cycle following the ack. A new request is sampled only in IDLE.
- Simultaneous events: a write request while the buffer is valid misses, and the flag clears at the same edge the write is issued. A wbs_ack_i arriving in the same cycle as wbm_cyc_i falling is treated as an abort.

## Configuration
- WB_DATA_UPSIZE_RDBUF_EN
- Defined: read buffer present. Reads fetch the full word (sel 4'b1111), and same-word reads hit.
- Undefined: no buffer and no hit path. Every access goes to the slave with a one-hot sel, so a read costs the same as a write.

## Structure
- Package wb_data_upsize_pkg: state enum (IDLE/ACCESS/RESP), lane-select function (off→sel), byte-extract function (word, off→byte).
- Sub-module wb_data_upsize_rdbuf:
  - Holds the word, tag and valid flag.
  - Ports: fill, invalidate, lookup tag → hit, data.
  - Instantiated only under the macro.

## Test plan
- Write 0xA5 to 0x102 → one slave access with adr 0x100, sel 4'b0010, dat 0xA5A5A5A5. wbm_ack_o pulses once, 2 cycles after the request.
- With the buffer: read 0x200 with the slave returning 0x11223344 → master gets 0x11. A read of 0x203 then returns 0x44 in 1 cycle with wbs_stb_o staying low.
- With the buffer: read 0x200, write 0x201, read 0x202 → the third access reaches the slave (miss after invalidate). Repeat with wbm_cyc_i dropped between two reads → the second read misses.
- Slave err on a read of 0x300 → wbm_err_o pulses one cycle and wbm_ack_o stays 0. A following read of 0x300 goes to the slave.
- wbm_cyc_i dropped while the slave is stalled → wbs_cyc_o low next cycle. A late wbs_ack_i is ignored and no master response is produced.
- wb_rst_n_i asserted during ACCESS → all outputs 0 immediately. The first request after release behaves as a miss.
